// File: rtl/mux_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// find_ch returns {found, channel} for the lowest enabled channel at or above 'from'.
package mux_pkg;

  localparam int CH_NUM = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  function automatic logic [CH_W:0] find_ch(input logic [CH_NUM-1:0] mask,
                                            input logic [CH_W:0]     from);
    logic [CH_W:0] r;
    r = '0;
    // Walk downwards so the last hit is the lowest qualifying channel.
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (mask[i] && ((CH_W + 1)'(i) >= from)) begin
        r = {1'b1, i[CH_W-1:0]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_settle_cnt.sv
// Settle-time counter: reloads to zero on load, counts while enabled,
// and flags the last settle cycle of the current channel with tc.
module mux_settle_cnt #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign tc = en && (cnt_q == 8'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the selects over the enabled channels,
// samples mux_out after each settle period and hands the word out on valid/ready.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_NUM-1:0] ch_en,
  output logic              s0,
  output logic              s1,
  input  logic              mux_out,
  output logic [CH_NUM-1:0] word,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output state_t            state_dbg
);

  // Handshake: word is transferred on any edge where valid && ready are both
  // high; valid then stays high with word stable until that edge happens.

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic [CH_NUM-1:0] mask_q, mask_d;
  logic [CH_NUM-1:0] shadow_q, shadow_d;
  logic [CH_NUM-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              cnt_load;
  logic              cnt_en;
  logic              tc;
  logic              accept;
  logic [CH_W:0]     nxt;
  logic [CH_W:0]     first;

  mux_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .tc   (tc)
  );

  assign cnt_en = (state_q == SETTLE);
  assign accept = start && ((state_q == IDLE) || ((state_q == HOLD) && ready));
  assign nxt    = find_ch(mask_q, {1'b0, ch_q} + 3'd1);
  assign first  = find_ch(ch_en, '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      sel_q    <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      sel_q    <= sel_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    sel_d    = sel_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    cnt_load = 1'b0;

    case (state_q)
      IDLE: begin
        sel_d = '0;
      end
      SETTLE: begin
        if (tc) begin
          shadow_d[ch_q] = mux_out;
          if (nxt[CH_W]) begin
            ch_d     = nxt[CH_W-1:0];
            sel_d    = nxt[CH_W-1:0];
            cnt_load = 1'b1;
          end else begin
            word_d  = shadow_d;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            sel_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new scan overrides the plain IDLE/HOLD outcome, giving back-to-back scans.
    if (accept) begin
      mask_d   = ch_en;
      shadow_d = '0;
      if (first[CH_W]) begin
        state_d  = SETTLE;
        ch_d     = first[CH_W-1:0];
        sel_d    = first[CH_W-1:0];
        cnt_load = 1'b1;
        busy_d   = 1'b1;
        valid_d  = 1'b0;
      end else begin
        state_d = HOLD;
        word_d  = '0;
        valid_d = 1'b1;
      end
    end
  end

  assign s1        = sel_q[1];
  assign s0        = sel_q[0];
  assign word      = word_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 4:1 mux on its selects.
// Table-driven scans plus hand-written reset and back-to-back sequences.
module tb_mux_scan_ctrl;
  import mux_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] ch_en;
  logic       s0;
  logic       s1;
  logic       mux_out;
  logic [3:0] word;
  logic       valid;
  logic       ready;
  logic       busy;
  state_t     state_dbg;
  logic [3:0] d;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  typedef struct {
    logic [3:0] ch_en;
    logic [3:0] d;
    logic [3:0] exp_word;
    int         lat;
    int         hold;
  } vec_t;

  vec_t       vecs[6];
  logic [3:0] b2b_d[3];

  always #5 clk = ~clk;

  assign mux_out = d[{s1, s0}];

  mux_scan_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ch_en     (ch_en),
    .s0        (s0),
    .s1        (s1),
    .mux_out   (mux_out),
    .word      (word),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic run_scan(input logic [3:0] en, input logic [3:0] dv,
                          input logic [3:0] wexp, input int lat, input int hold);
    int n;
    exp_q.delete();
    got_q.delete();
    for (int c = 0; c < 4; c++) begin
      if (en[c]) begin
        exp_q.push_back(4'(c));
        exp_q.push_back(4'(c));
      end
    end
    d     = dv;
    ch_en = en;
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ch_en = ~en;
    n = 0;
    while (!valid && n < 100) begin
      check("busy_in_scan", busy, 1);
      got_q.push_back({2'b00, s1, s0});
      start = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    start = 1'b0;
    check("latency", n, lat);
    check("sel_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check("sel_seq", got_q[i], exp_q[i]);
    end
    check("word_done", word, wexp);
    check("busy_done", busy, 0);
    check("sel_done", {s1, s0}, 0);
    check("state_hold", state_dbg, HOLD);
    for (int i = 0; i < hold; i++) begin
      start = 1'b1;
      tick();
      check("valid_stall", valid, 1);
      check("word_stall", word, wexp);
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("valid_drop", valid, 0);
    check("state_idle", state_dbg, IDLE);
    check("sel_idle", {s1, s0}, 0);
    check("word_retained", word, wexp);
  endtask

  initial begin
    vecs[0] = '{ch_en: 4'b1111, d: 4'b1010, exp_word: 4'b1010, lat: 8, hold: 5};
    vecs[1] = '{ch_en: 4'b0101, d: 4'b1111, exp_word: 4'b0101, lat: 4, hold: 2};
    vecs[2] = '{ch_en: 4'b0000, d: 4'b1111, exp_word: 4'b0000, lat: 0, hold: 1};
    vecs[3] = '{ch_en: 4'b1000, d: 4'b1000, exp_word: 4'b1000, lat: 2, hold: 0};
    vecs[4] = '{ch_en: 4'b0110, d: 4'b0100, exp_word: 4'b0100, lat: 4, hold: 0};
    vecs[5] = '{ch_en: 4'b1111, d: 4'b0110, exp_word: 4'b0110, lat: 8, hold: 3};
    b2b_d[0] = 4'b0110;
    b2b_d[1] = 4'b1001;
    b2b_d[2] = 4'b1111;

    rst   = 1'b1;
    start = 1'b0;
    ch_en = 4'b0000;
    ready = 1'b0;
    d     = 4'b0000;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_sel", {s1, s0}, 0);
    check("rst_word", word, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, IDLE);

    for (int v = 0; v < 6; v++) begin
      run_scan(vecs[v].ch_en, vecs[v].d, vecs[v].exp_word, vecs[v].lat, vecs[v].hold);
    end

    // Reset while channel 2 is selected.
    begin
      int n;
      d     = 4'b1010;
      ch_en = 4'b1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while ({s1, s0} != 2'd2 && n < 20) begin
        tick();
        n++;
      end
      check("reach_ch2", {s1, s0}, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_sel", {s1, s0}, 0);
      check("mid_rst_valid", valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_word", word, 0);
      check("mid_rst_state", state_dbg, IDLE);
    end
    run_scan(4'b1111, 4'b1010, 4'b1010, 8, 0);

    // Back-to-back scans with start and ready held high.
    begin
      int n;
      ch_en = 4'b1111;
      d     = b2b_d[0];
      ready = 1'b1;
      start = 1'b1;
      tick();
      check("b2b_busy_first", busy, 1);
      for (int s = 0; s < 3; s++) begin
        n = 0;
        while (!valid && n < 100) begin
          tick();
          n++;
        end
        check("b2b_latency", n, 8);
        check("b2b_word", word, b2b_d[s]);
        if (s < 2) begin
          d = b2b_d[s + 1];
          tick();
          check("b2b_valid_drop", valid, 0);
          check("b2b_busy_restart", busy, 1);
          check("b2b_state", state_dbg, SETTLE);
        end
      end
      start = 1'b0;
      tick();
      ready = 1'b0;
      check("b2b_end_valid", valid, 0);
      check("b2b_end_state", state_dbg, IDLE);
      check("b2b_end_word", word, b2b_d[2]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
